// File: rtl/control_word_executor.sv
// control_word_executor: control-unit back end; registers the decoder control word, IR, micro-state, NZCV and retire count
// Ports: clock/reset (async, active-high); instr_in, cw_in, next_state_in, k_in, alu_status, stall in;
// instruction/state feed the decoders; Psel..PCsel unpack the registered word; reg_write/ram_write are
// gated enables; K registered constant; status NZCV; retire_count completed ops; illegal_state sticky flag.
module control_word_executor #(
  parameter int          CNT_WIDTH = 16,
  parameter logic [31:0] IR_RESET  = 32'h0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [31:0]          instr_in,
  input  logic [28:0]          cw_in,
  input  logic [1:0]           next_state_in,
  input  logic [63:0]          k_in,
  input  logic [3:0]           alu_status,
  input  logic                 stall,
  output logic [31:0]          instruction,
  output logic [1:0]           state,
  output logic [1:0]           Psel,
  output logic [4:0]           DA,
  output logic [4:0]           SA,
  output logic [4:0]           SB,
  output logic [4:0]           Fsel,
  output logic [1:0]           Dsel,
  output logic                 Bsel,
  output logic                 PCsel,
  output logic                 reg_write,
  output logic                 ram_write,
  output logic [63:0]          K,
  output logic [3:0]           status,
  output logic [CNT_WIDTH-1:0] retire_count,
  output logic                 illegal_state
);
  logic [28:0] cw_q;
  logic        cw_valid;
  logic        bad_ns;
  logic [1:0]  ns;
  assign bad_ns = next_state_in == 2'b11;
  assign ns     = bad_ns ? 2'b00 : next_state_in;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      instruction   <= IR_RESET;
      state         <= 2'b00;
      cw_q          <= '0;
      cw_valid      <= 1'b0;
      K             <= '0;
      status        <= '0;
      retire_count  <= '0;
      illegal_state <= 1'b0;
    end else if (!stall) begin
      cw_q     <= cw_in;
      K        <= k_in;
      cw_valid <= 1'b1;
      state    <= ns;
      if (bad_ns) illegal_state <= 1'b1;
      // an op retires (and the next instruction is taken) only when the micro-sequence returns to 00
      if (ns == 2'b00) begin
        instruction  <= instr_in;
        retire_count <= retire_count + CNT_WIDTH'(1);
      end
      // flags produced by the ALU belong to the word currently driving the datapath
      if (cw_valid && cw_q[0]) status <= alu_status;
    end
  end
  assign Psel      = cw_q[28:27];
  assign DA        = cw_q[26:22];
  assign SA        = cw_q[21:17];
  assign SB        = cw_q[16:12];
  assign Fsel      = cw_q[11:7];
  assign Dsel      = cw_q[4:3];
  assign Bsel      = cw_q[2];
  assign PCsel     = cw_q[1];
  assign reg_write = cw_q[6] & cw_valid & ~stall;
  assign ram_write = cw_q[5] & cw_valid & ~stall;
endmodule

// File: tb/tb_control_word_executor.sv
// tb_control_word_executor: scoreboard bench for control_word_executor
module tb_control_word_executor;
  localparam int F_IR = 0, F_ST = 1, F_DA = 2, F_SA = 3, F_SB = 4, F_FS = 5, F_PS = 6, F_DS = 7;
  localparam int F_BS = 8, F_PC = 9, F_RW = 10, F_MW = 11, F_K = 12, F_STA = 13, F_CNT = 14, F_ILL = 15;
  localparam logic [31:0] IRR = 32'hDEAD_BEEF;
  logic        clock = 0, reset = 1, stall = 1;
  logic [31:0] instr_in = 0;
  logic [28:0] cw_in = 0;
  logic [1:0]  next_state_in = 0;
  logic [63:0] k_in = 0;
  logic [3:0]  alu_status = 0;
  logic [31:0] instruction;
  logic [1:0]  state, Psel, Dsel;
  logic [4:0]  DA, SA, SB, Fsel;
  logic        Bsel, PCsel, reg_write, ram_write, illegal_state;
  logic [63:0] K;
  logic [3:0]  status, retire_count;
  typedef struct {string name; int f; logic [63:0] v;} exp_t;
  exp_t q[$];
  int n_checks = 0, n_fail = 0, cnt_m;
  bit done = 0;
  control_word_executor #(.CNT_WIDTH(4), .IR_RESET(IRR)) dut (
    .clock(clock), .reset(reset), .instr_in(instr_in), .cw_in(cw_in), .next_state_in(next_state_in),
    .k_in(k_in), .alu_status(alu_status), .stall(stall), .instruction(instruction), .state(state),
    .Psel(Psel), .DA(DA), .SA(SA), .SB(SB), .Fsel(Fsel), .Dsel(Dsel), .Bsel(Bsel), .PCsel(PCsel),
    .reg_write(reg_write), .ram_write(ram_write), .K(K), .status(status), .retire_count(retire_count),
    .illegal_state(illegal_state)
  );
  always #5 clock = ~clock;
  function automatic logic [63:0] act(int f);
    case (f)
      F_IR:    return 64'(instruction);
      F_ST:    return 64'(state);
      F_DA:    return 64'(DA);
      F_SA:    return 64'(SA);
      F_SB:    return 64'(SB);
      F_FS:    return 64'(Fsel);
      F_PS:    return 64'(Psel);
      F_DS:    return 64'(Dsel);
      F_BS:    return 64'(Bsel);
      F_PC:    return 64'(PCsel);
      F_RW:    return 64'(reg_write);
      F_MW:    return 64'(ram_write);
      F_K:     return K;
      F_STA:   return 64'(status);
      F_CNT:   return 64'(retire_count);
      default: return 64'(illegal_state);
    endcase
  endfunction
  always @(negedge clock) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_checks++;
      if (act(e.f) !== e.v) begin
        n_fail++;
        $display("FAIL %s: got %0h expected %0h", e.name, act(e.f), e.v);
      end
    end
  end
  initial begin
    #100000;
    if (!done) begin
      n_fail++;
      $display("FAIL timeout: test did not complete");
      $finish;
    end
  end
  task automatic ex(input string n, input int f, input logic [63:0] v);
    q.push_back('{name: n, f: f, v: v});
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic drive(input logic [31:0] i, input logic [28:0] c, input logic [1:0] n,
                       input logic [63:0] k, input logic [3:0] a, input logic s);
    instr_in = i; cw_in = c; next_state_in = n; k_in = k; alu_status = a; stall = s;
  endtask
  initial begin
    tick(); tick();
    n_checks++;
    if (instruction !== IRR || state !== 2'b00 || reg_write !== 1'b0 || ram_write !== 1'b0 ||
        K !== 64'h0 || status !== 4'h0 || retire_count !== 4'h0 || illegal_state !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state: ir=%0h st=%0h rw=%0b mw=%0b cnt=%0h ill=%0b",
               instruction, state, reg_write, ram_write, retire_count, illegal_state);
    end
    ex("rst_ir", F_IR, 64'(IRR)); ex("rst_state", F_ST, 0); ex("rst_rw", F_RW, 0); ex("rst_mw", F_MW, 0);
    ex("rst_k", F_K, 0); ex("rst_status", F_STA, 0); ex("rst_cnt", F_CNT, 0); ex("rst_ill", F_ILL, 0);
    ex("rst_da", F_DA, 0); ex("rst_fsel", F_FS, 0);
    tick();
    reset = 0;
    drive(32'h1111_0001, 29'h0A4_3C65, 2'b00, 64'h0123_4567_89AB_CDEF, 4'b0101, 0);
    ex("first_rw", F_RW, 0); ex("first_ir", F_IR, 64'(IRR));
    tick();
    drive(32'h1111_0002, 29'h0, 2'b00, 64'h0, 4'b0101, 0);
    ex("t2_da", F_DA, 2); ex("t2_sa", F_SA, 18); ex("t2_sb", F_SB, 3); ex("t2_fsel", F_FS, 24);
    ex("t2_psel", F_PS, 0); ex("t2_dsel", F_DS, 0); ex("t2_bsel", F_BS, 1); ex("t2_pcsel", F_PC, 0);
    ex("t2_rw", F_RW, 1); ex("t2_mw", F_MW, 1); ex("t2_k", F_K, 64'h0123_4567_89AB_CDEF);
    ex("t2_ir", F_IR, 64'h1111_0001); ex("t2_cnt", F_CNT, 1); ex("t2_status_pre", F_STA, 0);
    tick();
    drive(32'h1111_0003, 29'h40, 2'b01, 64'h0, 4'b1111, 0);
    ex("t2_status", F_STA, 4'b0101); ex("t2_cnt2", F_CNT, 2); ex("t2_ir2", F_IR, 64'h1111_0002);
    ex("t2_rw_off", F_RW, 0);
    tick();
    drive(32'h1111_0004, 29'h40, 2'b10, 64'h0123_4567_89AB_CDEF, 4'b1111, 0);
    ex("mc_s1", F_ST, 1); ex("mc_ir1", F_IR, 64'h1111_0002); ex("mc_cnt1", F_CNT, 2); ex("mc_rw1", F_RW, 1);
    ex("mc_status_noSL", F_STA, 4'b0101);
    tick();
    drive(32'h1111_0005, 29'h20, 2'b00, 64'hFFFF, 4'b1111, 1);
    for (int i = 0; i < 3; i++) begin
      ex("stall_state", F_ST, 2); ex("stall_rw", F_RW, 0); ex("stall_mw", F_MW, 0);
      ex("stall_ir", F_IR, 64'h1111_0002); ex("stall_cnt", F_CNT, 2);
      ex("stall_k", F_K, 64'h0123_4567_89AB_CDEF);
      tick();
    end
    drive(32'h1111_0005, 29'h20, 2'b00, 64'h55, 4'b1111, 0);
    ex("resume_state", F_ST, 2); ex("resume_rw", F_RW, 1); ex("resume_cnt", F_CNT, 2);
    tick();
    drive(32'h1111_0006, 29'h0, 2'b11, 64'h0, 4'b0000, 1);
    ex("mc_s0", F_ST, 0); ex("mc_ir3", F_IR, 64'h1111_0005); ex("mc_cnt3", F_CNT, 3);
    ex("mc_mw", F_MW, 0); ex("mc_k", F_K, 64'h55);
    tick();
    drive(32'h1111_0006, 29'h0, 2'b11, 64'h0, 4'b0000, 0);
    ex("stall_ill", F_ILL, 0); ex("stall_ill_cnt", F_CNT, 3); ex("stall_ill_ir", F_IR, 64'h1111_0005);
    ex("unstalled_mw", F_MW, 1);
    tick();
    drive(32'h1111_0007, 29'h0, 2'b00, 64'h0, 4'b0000, 0);
    ex("ill_flag", F_ILL, 1); ex("ill_state", F_ST, 0); ex("ill_ir", F_IR, 64'h1111_0006); ex("ill_cnt", F_CNT, 4);
    tick();
    cnt_m = 5;
    for (int i = 0; i < 16; i++) begin
      drive(32'h2222_0000 + 32'(i), 29'h0, 2'b00, 64'h0, 4'b0000, 0);
      ex("wrap_cnt", F_CNT, 64'(cnt_m)); ex("ill_sticky", F_ILL, 1);
      tick();
      cnt_m = (cnt_m + 1) % 16;
    end
    drive(32'h3333_0000, 29'h40, 2'b01, 64'h0, 4'b0000, 0);
    ex("wrap_final", F_CNT, 64'(cnt_m));
    tick();
    ex("pre_rst_state", F_ST, 1); ex("pre_rst_rw", F_RW, 1);
    tick();
    reset = 1;
    #1;
    ex("mid_rst_state", F_ST, 0); ex("mid_rst_rw", F_RW, 0); ex("mid_rst_ill", F_ILL, 0);
    ex("mid_rst_cnt", F_CNT, 0); ex("mid_rst_ir", F_IR, 64'(IRR));
    tick();
    reset = 0;
    @(negedge clock);
    #1;
    done = 1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
